// File: rtl/popcount_accumulator.sv
// -----------------------------------------------------------------------------
// popcount_accumulator
//
// Adds up the per-frame ones-counts (0..15) from the upstream 15-input
// ones-counter over FRAMES frames. Each completed block total is loaded into
// a one-entry output register and offered downstream with a valid/ready
// handshake. Accumulation of the next block keeps going while the consumer
// stalls. Only the final frame of a block waits for the held result to drain.
//
// Parameters
//   FRAMES  frames per block, 1..255
//   ACC_W   accumulator/result width, 2**ACC_W must exceed 15*FRAMES
//   THRESH  threshold for the 'over' flag (sum_out >= THRESH)
//
// Ports
//   clk        in   clock, rising-edge active
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous restart of the current block; drops any
//                   same-cycle frame and discards the held result's valid
//   cnt_in     in   [3:0] frame ones-count
//   in_valid   in   cnt_in valid
//   in_ready   out  frame accepted this cycle when in_valid is also high
//   sum_out    out  [ACC_W-1:0] block total
//   over       out  sum_out >= THRESH, registered with sum_out
//   sum_valid  out  sum_out/over hold an untaken result
//   sum_ready  in   consumer takes the result this cycle
// -----------------------------------------------------------------------------
module popcount_accumulator #(
    parameter int          FRAMES = 4,
    parameter int          ACC_W  = 8,
    parameter int unsigned THRESH = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [3:0]       cnt_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             over,
    output logic             sum_valid,
    input  logic             sum_ready
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    localparam longint unsigned MAX_SUM = 64'(15) * 64'(FRAMES);

    if (FRAMES < 1 || FRAMES > 255) begin : g_bad_frames
        $error("popcount_accumulator: FRAMES must be in 1..255");
    end

    if (ACC_W < 64 && ((64'd1 << ACC_W) <= MAX_SUM)) begin : g_bad_acc_w
        $error("popcount_accumulator: ACC_W too narrow for 15*FRAMES");
    end

    // Compare width wide enough for both the sum and THRESH, so a THRESH that
    // the sum can never reach is not truncated into a reachable value.
    localparam int CW = (ACC_W > 32) ? ACC_W : 32;

    localparam logic [7:0] LAST_IDX = 8'(FRAMES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [7:0]       fcnt_q,  fcnt_d;
    logic [ACC_W-1:0] sum_q,   sum_d;
    logic             over_q,  over_d;

    logic             last_frame;
    logic             accept;
    logic             handoff;
    logic [ACC_W-1:0] acc_plus;

    assign last_frame = (fcnt_q == LAST_IDX);
    assign sum_valid  = (state_q == FULL);
    assign handoff    = sum_valid && sum_ready;

    // Only the closing frame needs somewhere to put its result; it may go in
    // when the register is empty or being drained in this very cycle.
    assign in_ready   = !(last_frame && sum_valid && !sum_ready);
    assign accept     = in_valid && in_ready;

    assign acc_plus   = acc_q + {{(ACC_W-4){1'b0}}, cnt_in};

    assign sum_out    = sum_q;
    assign over       = over_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fcnt_d  = fcnt_q;
        sum_d   = sum_q;
        over_d  = over_q;

        if (clear) begin
            // Restart wins over any same-cycle frame; the last result value
            // stays visible but is no longer offered.
            acc_d   = '0;
            fcnt_d  = '0;
            state_d = EMPTY;
        end else begin
            if (handoff) begin
                state_d = EMPTY;
            end

            if (accept) begin
                if (last_frame) begin
                    // A load in the handoff cycle overrides the EMPTY above,
                    // so back-to-back blocks see no bubble.
                    sum_d   = acc_plus;
                    over_d  = (CW'(acc_plus) >= CW'(THRESH));
                    acc_d   = '0;
                    fcnt_d  = '0;
                    state_d = FULL;
                end else begin
                    acc_d   = acc_plus;
                    fcnt_d  = fcnt_q + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            fcnt_q  <= '0;
            sum_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fcnt_q  <= fcnt_d;
            sum_q   <= sum_d;
            over_q  <= over_d;
        end
    end

endmodule

// File: tb/tb_popcount_accumulator.sv
// -----------------------------------------------------------------------------
// Bench for popcount_accumulator (FRAMES=4, ACC_W=8, THRESH=30).
// A queue-based model tracks the frames of the open block and the offered
// result; every falling edge the DUT outputs are compared against it. Directed
// scenarios add hand-computed literal expectations, then a randomized run
// exercises valid/ready/clear interleavings.
// -----------------------------------------------------------------------------
module tb_popcount_accumulator;

    localparam int          FRAMES = 4;
    localparam int          ACC_W  = 8;
    localparam int unsigned THRESH = 30;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [3:0]       cnt_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] sum_out;
    logic             over;
    logic             sum_valid;
    logic             sum_ready;

    always #5 clk = ~clk;

    popcount_accumulator #(
        .FRAMES (FRAMES),
        .ACC_W  (ACC_W),
        .THRESH (THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .cnt_in    (cnt_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_out   (sum_out),
        .over      (over),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready)
    );

    int nvec = 0;
    int nmis = 0;

    // ---------------- reference model ----------------
    int blk[$];          // counts of frames accepted in the open block
    int m_sum   = 0;     // last block total
    bit m_over  = 1'b0;
    bit m_valid = 1'b0;  // result still waiting for the consumer

    function automatic bit exp_ready();
        return !((blk.size() == FRAMES - 1) && m_valid && !sum_ready);
    endfunction

    initial begin : model
        bit rdy;
        bit acc;
        int s;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                blk.delete();
                m_sum   = 0;
                m_over  = 1'b0;
                m_valid = 1'b0;
            end else begin
                rdy = exp_ready();
                acc = in_valid && rdy;
                if (clear) begin
                    blk.delete();
                    m_valid = 1'b0;
                end else begin
                    if (m_valid && sum_ready) m_valid = 1'b0;
                    if (acc) begin
                        blk.push_back(int'(cnt_in));
                        if (blk.size() == FRAMES) begin
                            s = 0;
                            foreach (blk[i]) s += blk[i];
                            m_sum   = s;
                            m_over  = (s >= THRESH);
                            m_valid = 1'b1;
                            blk.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("model_in_ready",  int'(in_ready),  int'(exp_ready()));
            chk("model_sum_valid", int'(sum_valid), int'(m_valid));
            chk("model_sum_out",   int'(sum_out),   m_sum);
            chk("model_over",      int'(over),      int'(m_over));
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(input logic [3:0] v);
        int n;
        n        = 0;
        cnt_in   = v;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                cnt_in   = 4'($urandom);
                return;
            end
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                nvec++;
                nmis++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, expected an accept", n);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Check a freshly produced result at the next falling edge.
    task automatic expect_res(input string name, input int s, input bit o);
        @(negedge clk);
        chk({name, "_valid"}, int'(sum_valid), 1);
        chk({name, "_sum"},   int'(sum_out),   s);
        chk({name, "_over"},  int'(over),      int'(o));
        @(posedge clk); #1;
    endtask

    task automatic block4(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d, input int s, input bit o);
        send(a); send(b); send(c); send(d);
        expect_res(name, s, o);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        bit acc_prev;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        cnt_in    = 4'd0;
        sum_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_out",   int'(sum_out),   0);
        chk("rst_over",      int'(over),      0);
        chk("rst_sum_valid", int'(sum_valid), 0);
        chk("rst_in_ready",  int'(in_ready),  1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic and boundary blocks, consumer always ready.
        block4("basic31", 15, 15, 0, 1, 31, 1'b1);
        @(negedge clk);
        chk("basic31_one_cycle", int'(sum_valid), 0);
        @(posedge clk); #1;
        block4("basic10", 1, 2, 3, 4, 10, 1'b0);
        block4("zeros",   0, 0, 0, 0, 0,  1'b0);
        block4("max60",   15, 15, 15, 15, 60, 1'b1);
        block4("thresh30", 15, 15, 0, 0, 30, 1'b1);

        // Backpressure: 8 frames of 5 with a stalled consumer.
        sum_ready = 1'b0;
        block4("bp_first", 5, 5, 5, 5, 20, 1'b0);
        send(5); send(5); send(5);
        cnt_in   = 4'd5;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall_ready", int'(in_ready),  0);
        chk("bp_held_sum",    int'(sum_out),   20);
        chk("bp_held_valid",  int'(sum_valid), 1);
        @(posedge clk); #1;
        sum_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_res("bp_second", 20, 1'b0);

        // Bubbles between frames.
        send(3); idle(1); send(3); idle(1); send(3); idle(1); send(3);
        expect_res("bubbles", 12, 1'b0);

        // clear after two frames.
        send(9); send(9);
        clear = 1'b1; idle(1); clear = 1'b0;
        block4("clear_mid", 2, 2, 2, 2, 8, 1'b0);

        // clear together with a valid frame: the frame is dropped.
        send(1); send(1);
        cnt_in = 4'd7; in_valid = 1'b1; clear = 1'b1;
        idle(1);
        clear = 1'b0; in_valid = 1'b0;
        block4("clear_drop", 1, 1, 1, 1, 4, 1'b0);

        // Reset mid-block with a held result.
        sum_ready = 1'b0;
        block4("pre_rst", 2, 2, 2, 2, 8, 1'b0);
        send(2); send(2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_sum_out",   int'(sum_out),   0);
        chk("midrst_over",      int'(over),      0);
        chk("midrst_sum_valid", int'(sum_valid), 0);
        chk("midrst_in_ready",  int'(in_ready),  1);
        @(posedge clk); #1;
        rst       = 1'b0;
        sum_ready = 1'b1;
        block4("post_rst", 1, 1, 1, 1, 4, 1'b0);

        // Randomized traffic, checked by the model every cycle.
        acc_prev = 1'b0;
        repeat (3000) begin
            if (!in_valid || acc_prev) begin
                in_valid = ($urandom_range(0, 3) != 0);
                cnt_in   = 4'($urandom);
            end
            sum_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            acc_prev = in_valid && in_ready;
            @(posedge clk); #1;
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/popcount_accumulator.md
# popcount_accumulator

Accumulates the 4-bit ones-counts produced by the 15-input ones-counter stage over a fixed number of frames, then presents the block total with a valid/ready handshake. Sits directly downstream of the 15-input ones-counter. Each frame's count (0..15) arrives with a valid strobe, and the accumulated result feeds a threshold decision. A one-entry output register lets accumulation of the next block overlap with a stalled consumer.

## Interface
- FRAMES, default 4: frames per block. Legal range is 1..255.
- ACC_W, default 8: accumulator and result width. Must satisfy 2^ACC_W > 15*FRAMES; violation is an elaboration error.
- THRESH, default 30: threshold compared against the block total.
- clk, input, 1: single clock. All state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous restart of the current block.
- cnt_in, input, 4: frame ones-count, cnt_in[3] MSB. Wired from the counter's y[0] (MSB) through y[3] (LSB).
- in_valid, input, 1: cnt_in is valid this cycle.
- in_ready, output, 1: block accepts cnt_in this cycle.
- sum_out, output, ACC_W: block total.
- over, output, 1: sum_out >= THRESH. Registered together with sum_out.
- sum_valid, output, 1: sum_out and over are valid.
- sum_ready, input, 1: consumer takes the result this cycle.

## Operation
- Accept event: in_valid && in_ready.
- Internal state:
  - acc: ACC_W bits, partial sum.
  - fcnt: 8 bits, frames accepted in the current block.
  - Output register: sum_out, over, sum_valid.
- Output FSM has two states:
  - EMPTY: sum_valid=0.
  - FULL: sum_valid=1.
- Accept, not last frame (fcnt < FRAMES-1): acc <= acc + cnt_in and fcnt <= fcnt+1.
- Accept, last frame (fcnt == FRAMES-1):
  - sum_out <= acc + cnt_in.
  - over <= ((acc + cnt_in) >= THRESH).
  - acc <= 0 and fcnt <= 0.
  - FSM enters FULL.
- Result handoff: sum_valid && sum_ready → FSM returns to EMPTY. sum_out and over keep their values.
- Last-frame accept while FULL with sum_ready=1 in the same cycle: the new result loads and the FSM stays FULL. There is no bubble.
- in_ready = !(fcnt == FRAMES-1 && sum_valid && !sum_ready). This is combinational from sum_ready and registered state.
  - Non-final frames are always accepted, so accumulation overlaps a stalled consumer.
  - Only the final frame stalls.
- FRAMES=1: every accept is a last-frame accept. sum_out equals cnt_in, zero-extended.
- Arithmetic: unsigned addition with cnt_in zero-extended to ACC_W. Overflow cannot occur given the ACC_W constraint.
- cnt_in is ignored when no accept occurs.
- clear:
  - Zeroes acc and fcnt, and forces the FSM to EMPTY. sum_out and over are held.
  - Takes priority over any same-cycle accept; that frame is dropped.
  - in_ready is unaffected by clear.
- rst, asynchronous: acc=0, fcnt=0, sum_out=0, over=0, sum_valid=0. in_ready is therefore 1 during and after reset.
- Reset mid-block discards the partial sum and any held result.

## Timing
- Latency: sum_valid rises on the clock edge of the last-frame accept, one cycle after the final cnt_in is presented. sum_out and over are valid in the same cycle.
- Peak throughput:
  - One frame per cycle.
  - One block per FRAMES cycles when sum_ready is held high.
- Handshake rules:
  - sum_out, over and sum_valid are stable while sum_valid && !sum_ready.
  - The upstream stage may change cnt_in only after an accept or while in_valid=0.
- Deassertion of rst may be asynchronous to clk. The first accept is permitted on the first clock edge after release.

## Test plan
- Basic block (FRAMES=4, THRESH=30, sum_ready=1):
  - Frames 15,15,0,1 → sum_out=31, over=1, sum_valid high for 1 cycle, one cycle after the 4th accept.
  - Frames 1,2,3,4 → sum_out=10, over=0.
- Boundary values:
  - Frames 0,0,0,0 → sum_out=0, over=0.
  - Frames 15,15,15,15 → sum_out=60, over=1.
  - THRESH exactly met with frames 15,15,0,0 → sum_out=30, over=1.
- Backpressure: sum_ready=0, stream 8 frames of 5 back-to-back.
  - First block: sum_out=20, held stable.
  - Frames 5–7 accepted. in_ready=0 while the 8th is offered.
  - Raise sum_ready → 8th accepted that cycle; next cycle sum_out=20 for the second block, sum_valid stays 1.
- Bubbles: in_valid toggles 1,0,1,0,... with frames 3,3,3,3 → sum_out=12 after the 4th accept. Idle cycles do not advance fcnt.
- clear after 2 frames of 9, then frames 2,2,2,2 → sum_out=8.
- clear in the same cycle as a valid frame → that frame is not counted.
- rst asserted mid-block with a held result → all outputs 0 immediately and in_ready=1. The next 4 frames of 1 → sum_out=4.
